// File: rtl/ss_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : ss_scan_ctrl
//  Purpose  : Time-multiplexed seven-segment scan controller. Holds a frame
//             of hex digits, strobes one active-low anode at a time with an
//             all-off guard interval before every slot, and presents the
//             selected nibble on o_dout for the downstream decoder.
//             Loads are double-buffered and committed only at frame
//             boundaries or while idle.
//  Options  : SS_LEADING_ZERO_BLANK_EN - blank leading zero digits.
//  Revision : 1.0 - initial release
// ============================================================================
module ss_scan_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int ON_CYC     = 100000,
  parameter int GUARD_CYC  = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_en,
  input  logic                    i_load,
  input  logic [4*NUM_DIGITS-1:0] i_din,
  input  logic [NUM_DIGITS-1:0]   i_blank_mask,
  output logic [3:0]              o_dout,
  output logic [NUM_DIGITS-1:0]   o_an,
  output logic                    o_load_ack,
  output logic                    o_frame_done
);

  localparam int C_CMAX = (ON_CYC > GUARD_CYC) ? ON_CYC : GUARD_CYC;
  localparam int C_CW   = $clog2(C_CMAX + 1);
  localparam int C_IW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [C_CW-1:0] C_GUARD_END = C_CW'(GUARD_CYC);
  localparam logic [C_CW-1:0] C_ON_END    = C_CW'(ON_CYC - 1);
  localparam logic [C_IW-1:0] C_LAST      = C_IW'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GUARD = 2'd1,
    S_ON    = 2'd2
  } state_t;

  state_t                  r_state, w_state_nxt;
  logic [C_CW-1:0]         r_cnt, w_cnt_nxt;
  logic [C_IW-1:0]         r_idx, w_idx_nxt;
  logic                    w_frame_end;

  logic [4*NUM_DIGITS-1:0] r_sh_din, r_act_din, w_act_din_nxt;
  logic [NUM_DIGITS-1:0]   r_sh_mask, r_act_mask, w_act_mask_nxt;
  logic                    r_pending, w_pending_nxt;
  logic                    w_commit, w_ack_nxt;

  logic [NUM_DIGITS-1:0]   w_blank;
  logic [NUM_DIGITS-1:0]   w_an_nxt;
  logic [3:0]              w_dout_nxt;
  logic                    w_fd_nxt;

  logic [NUM_DIGITS-1:0]   r_an;
  logic [3:0]              r_dout;
  logic                    r_load_ack;
  logic                    r_frame_done;

  // Scan sequencer state register: state, slot counter and digit index.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // Next-state logic. The guard after leaving IDLE starts its count at 0
  // while later guards start at 1, so the first anode goes low GUARD_CYC+1
  // cycles after enable while steady-state guards stay GUARD_CYC long.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_frame_end = 1'b0;
    if (!i_en) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
      w_idx_nxt   = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_nxt = S_GUARD;
          w_cnt_nxt   = '0;
          w_idx_nxt   = '0;
        end
        S_GUARD: begin
          if (r_cnt == C_GUARD_END) begin
            w_state_nxt = S_ON;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        S_ON: begin
          if (r_cnt == C_ON_END) begin
            w_state_nxt = S_GUARD;
            w_cnt_nxt   = C_CW'(1);
            if (r_idx == C_LAST) begin
              w_idx_nxt   = '0;
              w_frame_end = 1'b1;
            end else begin
              w_idx_nxt = r_idx + 1'b1;
            end
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
          w_idx_nxt   = '0;
        end
      endcase
    end
  end

  // Double-buffer commit: a load arriving on a commit edge bypasses the shadow.
  always_comb begin
    w_commit       = w_frame_end || (r_state == S_IDLE);
    w_act_din_nxt  = r_act_din;
    w_act_mask_nxt = r_act_mask;
    w_pending_nxt  = r_pending;
    w_ack_nxt      = 1'b0;
    if (w_commit) begin
      if (i_load) begin
        w_act_din_nxt  = i_din;
        w_act_mask_nxt = i_blank_mask;
        w_ack_nxt      = 1'b1;
      end else if (r_pending) begin
        w_act_din_nxt  = r_sh_din;
        w_act_mask_nxt = r_sh_mask;
        w_ack_nxt      = 1'b1;
      end
      w_pending_nxt = 1'b0;
    end else if (i_load) begin
      w_pending_nxt = 1'b1;
    end
  end

`ifdef SS_LEADING_ZERO_BLANK_EN
  logic w_zero_run;

  // Per-digit blanking: mask bit, or a zero digit with only zeros above it.
  always_comb begin
    w_blank    = w_act_mask_nxt;
    w_zero_run = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      w_zero_run = w_zero_run && (w_act_din_nxt[4*i +: 4] == 4'h0);
      if ((i > 0) && w_zero_run) begin
        w_blank[i] = 1'b1;
      end
    end
  end
`else
  // Per-digit blanking comes from the mask only.
  always_comb begin
    w_blank = w_act_mask_nxt;
  end
`endif

  // Output values computed from the post-edge state so they change with it.
  always_comb begin
    w_an_nxt = '1;
    if ((w_state_nxt == S_ON) && !w_blank[w_idx_nxt]) begin
      w_an_nxt[w_idx_nxt] = 1'b0;
    end
    w_dout_nxt = w_act_din_nxt[{w_idx_nxt, 2'b00} +: 4];
    w_fd_nxt   = (w_state_nxt == S_ON) && (w_cnt_nxt == C_ON_END) &&
                 (w_idx_nxt == C_LAST);
  end

  // Data registers and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sh_din     <= '0;
      r_sh_mask    <= '0;
      r_act_din    <= '0;
      r_act_mask   <= '0;
      r_pending    <= 1'b0;
      r_an         <= '1;
      r_dout       <= 4'h0;
      r_load_ack   <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      if (i_load) begin
        r_sh_din  <= i_din;
        r_sh_mask <= i_blank_mask;
      end
      r_act_din    <= w_act_din_nxt;
      r_act_mask   <= w_act_mask_nxt;
      r_pending    <= w_pending_nxt;
      r_an         <= w_an_nxt;
      r_dout       <= w_dout_nxt;
      r_load_ack   <= w_ack_nxt;
      r_frame_done <= w_fd_nxt;
    end
  end

  assign o_an         = r_an;
  assign o_dout       = r_dout;
  assign o_load_ack   = r_load_ack;
  assign o_frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_ss_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ss_scan_ctrl
//  Purpose  : Self-checking bench for ss_scan_ctrl (4 digits, ON=4, GUARD=1)
//             using a position-arithmetic reference model.
//  Options  : SS_LEADING_ZERO_BLANK_EN changes the expected blanking.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ss_scan_ctrl;

  localparam int N     = 4;
  localparam int ON    = 4;
  localparam int G     = 1;
  localparam int SLOT  = G + ON;
  localparam int FRAME = N * SLOT;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        load = 1'b0;
  logic [15:0] din = '0;
  logic [3:0]  mask = '0;
  logic [3:0]  dout;
  logic [3:0]  an;
  logic        ack;
  logic        fd;

  int total = 0;
  int bad   = 0;

  // reference model state
  bit          m_run;
  int          m_k;
  logic [15:0] m_sh_d, m_act_d;
  logic [3:0]  m_sh_m, m_act_m;
  bit          m_pend;
  logic [3:0]  e_an, e_dout;
  logic        e_ack, e_fd;

  ss_scan_ctrl #(.NUM_DIGITS(N), .ON_CYC(ON), .GUARD_CYC(G)) dut (
    .clk(clk), .rst_n(rst_n), .i_en(en), .i_load(load), .i_din(din),
    .i_blank_mask(mask), .o_dout(dout), .o_an(an), .o_load_ack(ack),
    .o_frame_done(fd)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // k counts cycles since the enabling edge; k=0 is the extra first guard,
  // afterwards slots of GUARD then ON repeat with period SLOT.
  function automatic bit in_on(input int k);
    return (k >= 1) && (((k - 1) % SLOT) >= G);
  endfunction
  function automatic int digit(input int k);
    return (k == 0) ? 0 : (((k - 1) / SLOT) % N);
  endfunction
  function automatic bit last_on(input int k);
    return in_on(k) && (((k - 1) % SLOT) == SLOT - 1) && (digit(k) == N - 1);
  endfunction
  function automatic bit blanked(input int d);
    logic [15:0] upper;
    upper = m_act_d >> (4 * d);
    if (m_act_m[d]) return 1'b1;
`ifdef SS_LEADING_ZERO_BLANK_EN
    if ((d > 0) && (upper == 16'h0)) return 1'b1;
`endif
    return 1'b0;
  endfunction

  task automatic model(input bit rn, input bit e, input bit ld,
                       input logic [15:0] d, input logic [3:0] mk);
    bit boundary, commit;
    int dg;
    if (!rn) begin
      m_run = 0; m_k = 0; m_sh_d = '0; m_act_d = '0; m_sh_m = '0;
      m_act_m = '0; m_pend = 0;
      e_an = 4'hF; e_dout = 4'h0; e_ack = 0; e_fd = 0;
      return;
    end
    boundary = m_run && e && last_on(m_k);
    commit   = !m_run || boundary;
    e_ack    = commit && (ld || m_pend);
    if (ld) begin m_sh_d = d; m_sh_m = mk; end
    if (commit) begin
      if (ld || m_pend) begin m_act_d = m_sh_d; m_act_m = m_sh_m; end
      m_pend = 0;
    end else if (ld) begin
      m_pend = 1;
    end
    if (!e) begin
      m_run = 0; m_k = 0;
    end else if (!m_run) begin
      m_run = 1; m_k = 0;
    end else begin
      m_k = m_k + 1;
      if (m_k > FRAME) m_k = m_k - FRAME;
    end
    dg     = m_run ? digit(m_k) : 0;
    e_dout = m_act_d[4*dg +: 4];
    e_an   = 4'hF;
    if (m_run && in_on(m_k) && !blanked(dg)) e_an[dg] = 1'b0;
    e_fd   = m_run && last_on(m_k);
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input bit rn, input bit e, input bit ld,
                      input logic [15:0] d, input logic [3:0] mk);
    rst_n = rn; en = e; load = ld; din = d; mask = mk;
    @(posedge clk);
    model(rn, e, ld, d, mk);
    #1;
    chk("an", {12'h0, an}, {12'h0, e_an});
    chk("dout", {12'h0, dout}, {12'h0, e_dout});
    chk("load_ack", {15'h0, ack}, {15'h0, e_ack});
    chk("frame_done", {15'h0, fd}, {15'h0, e_fd});
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1, 1, 0, 16'($urandom), 4'($urandom));
  endtask

  initial begin
    int n;
    int acks;
    bit seen;
    logic [3:0] strobed;
    bit on_now;

    // reset
    for (int i = 0; i < 3; i++) step(0, 0, 0, 16'h0, 4'h0);

    // enable and measure first-anode latency
    step(1, 1, 0, 16'h0, 4'h0);
    n = 0;
    for (int i = 0; i < 20 && an == 4'hF; i++) begin
      step(1, 1, 0, 16'h0, 4'h0);
      n++;
    end
    chk("first_low", 16'(n), 16'(G + 1));
    run(2 * FRAME);

    // load while idle, then tear-free mid-frame load
    step(1, 0, 0, 16'h0, 4'h0);
    step(1, 0, 1, 16'h1234, 4'h0);
    chk("idle_ack", {15'h0, ack}, 16'h1);
    step(1, 1, 0, 16'h0, 4'h0);
    for (int i = 0; i < 40 && !(in_on(m_k) && digit(m_k) == 1); i++) run(1);
    step(1, 1, 1, 16'hABCD, 4'h0);
    run(2 * FRAME);

    // two loads in one frame: single ack, last wins
    for (int i = 0; i < 40 && !(in_on(m_k) && digit(m_k) == 0); i++) run(1);
    acks = 0;
    step(1, 1, 1, 16'h1111, 4'h0); acks += int'(ack);
    run(3);
    step(1, 1, 1, 16'h2222, 4'h0); acks += int'(ack);
    for (int i = 0; i < FRAME + 4; i++) begin
      step(1, 1, 0, 16'h0, 4'h0);
      acks += int'(ack);
    end
    chk("single_ack", 16'(acks), 16'h1);

    // load in the frame_done cycle commits directly
    for (int i = 0; i < 2 * FRAME && !e_fd; i++) run(1);
    step(1, 1, 1, 16'h3333, 4'h0);
    chk("bypass_ack", {15'h0, ack}, 16'h1);
    run(FRAME);

    // mask digit 2 and confirm it is never strobed
    step(1, 0, 1, 16'h5678, 4'b0100);
    step(1, 1, 0, 16'h0, 4'h0);
    seen = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      run(1);
      if (an == 4'b1011) seen = 1;
    end
    chk("mask_never", {15'h0, seen}, 16'h0);

    // drop enable in ON of digit 1, then restart from digit 0
    for (int i = 0; i < 40 && !(in_on(m_k) && digit(m_k) == 1); i++) run(1);
    step(1, 0, 0, 16'h0, 4'h0);
    chk("dis_dark", {12'h0, an}, 16'h000F);
    step(1, 0, 0, 16'h0, 4'h0);
    step(1, 1, 0, 16'h0, 4'h0);
    run(FRAME + 3);

    // mid-frame reset with a pending load
    for (int i = 0; i < 40 && !(in_on(m_k) && digit(m_k) == 0); i++) run(1);
    step(1, 1, 1, 16'h9999, 4'h0);
    for (int i = 0; i < 40 && !(in_on(m_k) && digit(m_k) == 2); i++) run(1);
    step(0, 1, 0, 16'h0, 4'h0);
    chk("rst_an", {12'h0, an}, 16'h000F);
    step(1, 1, 0, 16'h0, 4'h0);
    chk("rst_noack", {15'h0, ack}, 16'h0);
    run(FRAME);

    // leading-zero behaviour with 0x0050
    step(1, 0, 1, 16'h0050, 4'h0);
    step(1, 1, 0, 16'h0, 4'h0);
    strobed = 4'h0;
    for (int i = 0; i < FRAME + 2; i++) begin
      run(1);
      strobed = strobed | ~an;
    end
`ifdef SS_LEADING_ZERO_BLANK_EN
    chk("lz_strobed", {12'h0, strobed}, 16'h0003);
`else
    chk("lz_strobed", {12'h0, strobed}, 16'h000F);
`endif

    // randomized traffic
    on_now = 1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) == 0) on_now = !on_now;
      else if (!on_now && $urandom_range(0, 3) == 0) on_now = 1;
      step(($urandom_range(0, 599) != 0), on_now, ($urandom_range(0, 24) == 0),
           16'($urandom), ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
